serial_subtractor_nbit: RTL
===========================

# serial_subtractor_nbit

Bit-serial, parametrised-width subtractor. It computes d = a − b − b_in over WIDTH clock cycles, LSB first. Each cycle reuses one 1-bit subtract cell (difference = XOR, borrow from the ~a·b term) plus a registered borrow. It sits in the week-4 arithmetic set as the sequential successor of the 1-bit half subtractor. It adds borrow-in chaining, a start/busy/done handshake and signed-overflow detection.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled on rising clk edge.
- a  in  WIDTH  minuend; captured only on an accepted start.
- b  in  WIDTH  subtrahend; captured only on an accepted start.
- b_in  in  1  borrow-in; captured only on an accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- d  out  WIDTH  difference, registered; held until the next completion.
- b_out  out  1  final borrow (1 when the unsigned a < b + b_in).
- ovf  out  1  signed two's-complement overflow of a − b − b_in.

## Operation
- Internal state:
  - FSM states IDLE, SHIFT, DONE.
  - a_sh, b_sh: WIDTH-bit shift registers.
  - r_sh: WIDTH-bit result shift register.
  - br: 1-bit borrow register.
  - cnt: counter of ceil(log2(WIDTH+1)) bits.
- IDLE:
  - start=1 → load a_sh=a, b_sh=b, br=b_in, cnt=0, latch a[WIDTH-1] and b[WIDTH-1] for ovf; go to SHIFT.
  - start=0 → stay in IDLE.
- SHIFT, every cycle:
  - x = a_sh[0], y = b_sh[0].
  - Difference bit = x^y^br.
  - br ← (~x & y) | (~(x^y) & br).
  - Shift a_sh and b_sh right by 1.
  - Shift the difference bit into r_sh at the MSB.
  - cnt ← cnt+1.
- SHIFT exit: when cnt reaches WIDTH−1 on the current edge, the last bit is processed and the FSM goes to DONE. On that same edge:
  - d ← final r_sh contents (all WIDTH bits).
  - b_out ← final br.
  - ovf ← (a_msb ≠ b_msb) & (d[WIDTH-1] ≠ a_msb).
- DONE: lasts one cycle, then returns to IDLE. If start=1 in DONE, it is accepted exactly as in IDLE (back-to-back operation) and the FSM goes directly to SHIFT.
- start while in SHIFT is ignored. Operands are not re-captured and the operation in flight is unaffected.
- a, b and b_in may change freely after the accept edge.
- d, b_out and ovf change only on a completion edge. They are stable at all other times, including during SHIFT of the next operation.

## Timing
- Reset (asynchronous, immediate on rst_n=0): state=IDLE, busy=0, done=0, d=0, b_out=0, ovf=0, and all internal registers 0.
- Reset asserted mid-operation aborts it. No done is produced, and outputs return to their reset values.
- Edge E0 accepts start. From E0 through E(WIDTH): busy=1 for exactly WIDTH cycles.
- Edge E(WIDTH) updates the result.
- Between E(WIDTH) and E(WIDTH+1): done=1 and busy=0 for exactly one cycle.
- Latency, from start-accept edge to result-valid edge: WIDTH cycles.
- Throughput: one operation per WIDTH+1 cycles when start is held high.
- busy and done are registered outputs: state-decoded, with no combinational path from start.

## Test plan
- WIDTH=8, a=0x05, b=0x03, b_in=0 → after 8 cycles d=0x02, b_out=0, ovf=0. busy is high for exactly 8 cycles, then done pulses for 1 cycle.
- a=0x03, b=0x05, b_in=0 → d=0xFE, b_out=1, ovf=0. Then a=0x00, b=0x00, b_in=1 → d=0xFF, b_out=1, ovf=0.
- Signed overflow: a=0x80, b=0x01 → d=0x7F, b_out=0, ovf=1. Then a=0x7F, b=0xFF → d=0x80, b_out=1, ovf=1.
- Handshake:
  - Pulse start again at cycles 3 and 5 of an operation → ignored, and the result matches the first operands.
  - Change a and b after the accept edge → no effect on the result.
  - Hold start=1 continuously → a new operation every 9 cycles; d updates only on done edges.
- Reset mid-operation: assert rst_n=0 at cycle 4 of a=0xAA, b=0x55 → busy, done, d, b_out and ovf are 0 immediately (asynchronously). After release, a fresh a=0xAA, b=0x55 gives d=0x55, b_out=0, ovf=1.
- Exhaustive sweep at WIDTH=4, all a, b and b_in (512 cases) → each result equals the reference model ({b_out,d} = a − b − b_in, ovf per the signed rule). Also run one WIDTH=32 random regression of 1000 cases.

Source files
------------

// File: rtl/serial_subtractor_nbit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_nbit
//
// Bit-serial subtractor computing d = a - b - b_in over WIDTH clock cycles,
// LSB first. A single 1-bit subtract cell is reused every cycle. Its borrow is
// kept in a register between cycles.
//
// Handshake: start is accepted in IDLE or DONE. busy is high for exactly WIDTH
// cycles after the accept edge. done then pulses for one cycle, and at that
// point d / b_out / ovf hold the new result. The result registers change only
// on a completion edge.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request (ignored while busy)
//   a      in   [WIDTH-1:0] minuend, captured on accept
//   b      in   [WIDTH-1:0] subtrahend, captured on accept
//   b_in   in   borrow-in, captured on accept
//   busy   out  operation in progress (registered)
//   done   out  one-cycle completion pulse (registered)
//   d      out  [WIDTH-1:0] difference, held until next completion
//   b_out  out  final borrow (unsigned a < b + b_in)
//   ovf    out  signed two's-complement overflow of a - b - b_in
// -----------------------------------------------------------------------------
module serial_subtractor_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // FSM
    state_t state_q, state_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    // Datapath
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             b_out_q, b_out_d;
    logic             ovf_q, ovf_d;

    // 1-bit subtract cell
    logic             x, y;
    logic             diff_bit;
    logic             br_next;
    logic [WIDTH-1:0] r_next;

    logic             accept;
    logic             last_bit;

    // DONE accepts start just like IDLE, so back-to-back operations skip IDLE.
    assign accept   = start && (state_q != SHIFT);
    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    assign x        = a_sh_q[0];
    assign y        = b_sh_q[0];
    assign diff_bit = x ^ y ^ br_q;
    assign br_next  = (~x & y) | (~(x ^ y) & br_q);
    // Difference bits enter at the MSB so that after WIDTH shifts the LSB
    // computed first has reached bit 0.
    assign r_next   = {diff_bit, r_sh_q[WIDTH-1:1]};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // busy/done are decoded from the next state and then registered. This
    // keeps them aligned with state_q and leaves no combinational path from
    // start to the outputs.
    always_comb begin
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        b_out_d = b_out_q;
        ovf_d   = ovf_q;

        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b;
            r_sh_d  = '0;
            br_d    = b_in;
            cnt_d   = '0;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end else if (state_q == SHIFT) begin
            a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            r_sh_d = r_next;
            br_d   = br_next;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last_bit) begin
                d_d     = r_next;
                b_out_d = br_next;
                // Overflow is only possible when the operand signs differ.
                // It has occurred when the result sign differs from the
                // minuend sign.
                ovf_d   = (a_msb_q ^ b_msb_q) & (r_next[WIDTH-1] ^ a_msb_q);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            b_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            b_out_q <= b_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign d     = d_q;
    assign b_out = b_out_q;
    assign ovf   = ovf_q;

endmodule
